// File: rtl/pl_adc_capture.sv
// rtl/pl_adc_capture.sv - CMOS ADC capture engine: start-edge triggered, decimated, valid/ready sample stream.
module pl_adc_capture #(
    parameter int DATA_W      = 14,
    parameter int CNT_W       = 20,
    parameter int DEFAULT_LEN = 200000
) (
    input  logic              i_CMOS_Clk,
    input  logic              i_Rst_n,
    input  logic [DATA_W-1:0] i_CMOS_Data,
    input  logic              i_ADC_Work,
    input  logic              i_Abort,
    input  logic [1:0]        i_Mode,
    input  logic [CNT_W-1:0]  i_Len,
    input  logic [7:0]        i_Decim,
    output logic [DATA_W-1:0] o_CMOS_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic              o_Busy,
    output logic              o_ADC_Done,
    output logic              o_Aborted,
    output logic              o_Overrun,
    output logic [CNT_W-1:0]  o_Sample_Cnt
);

    localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEFAULT_LEN);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic               work_q, work_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         decim_q, decim_d;
    logic [7:0]         dcnt_q, dcnt_d;
    logic [DATA_W-1:0]  pat_q, pat_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               start_edge;
    logic               xfer;
    logic               emit;
    logic [DATA_W-1:0]  chk;
    logic [DATA_W-1:0]  src;

    assign start_edge = i_ADC_Work & ~work_q;
    assign xfer       = valid_q & i_Ready;
    assign emit       = (state_q == S_CAPTURE) && (dcnt_q == 8'd0);

    // Checkerboard: odd bit positions set on even emits, phase flips every emit.
    always_comb begin
        chk = '0;
        for (int i = 0; i < DATA_W; i++) begin
            chk[i] = i[0] ^ pat_q[0];
        end
    end

    always_comb begin
        case (mode_q)
            2'd1:    src = pat_q;
            2'd2:    src = chk;
            default: src = data_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        work_d    = i_ADC_Work;
        data_d    = i_CMOS_Data;
        len_d     = len_q;
        mode_d    = mode_q;
        decim_d   = decim_q;
        dcnt_d    = dcnt_q;
        pat_d     = pat_q;
        out_d     = out_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;

        if (xfer) begin
            valid_d = 1'b0;
        end

        if (i_Abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_d   = S_CAPTURE;
                        len_d     = (i_Len == '0) ? DEF_LEN : i_Len;
                        mode_d    = i_Mode;
                        decim_d   = i_Decim;
                        dcnt_d    = 8'd0;
                        pat_d     = '0;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        aborted_d = 1'b0;
                        overrun_d = 1'b0;
                    end
                end
                S_CAPTURE: begin
                    dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
                    if (emit) begin
                        out_d   = src;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        pat_d   = pat_q + DATA_W'(1);
                        if (valid_q && !i_Ready) begin
                            overrun_d = 1'b1;
                        end
                        if (cnt_q + CNT_W'(1) == len_q) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!valid_q || i_Ready) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            work_q    <= 1'b0;
            data_q    <= '0;
            len_q     <= '0;
            mode_q    <= 2'd0;
            decim_q   <= 8'd0;
            dcnt_q    <= 8'd0;
            pat_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            data_q    <= data_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            decim_q   <= decim_d;
            dcnt_q    <= dcnt_d;
            pat_q     <= pat_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_CMOS_Data  = out_q;
    assign o_Valid      = valid_q;
    assign o_Busy       = busy_q;
    assign o_ADC_Done   = done_q;
    assign o_Aborted    = aborted_q;
    assign o_Overrun    = overrun_q;
    assign o_Sample_Cnt = cnt_q;

endmodule

// File: tb/tb_pl_adc_capture.sv
// tb/tb_pl_adc_capture.sv - randomized scoreboard bench for pl_adc_capture.
module tb_pl_adc_capture;

    localparam int DW   = 14;
    localparam int CW   = 20;
    localparam int DLEN = 40;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] i_CMOS_Data;
    logic          i_ADC_Work;
    logic          i_Abort;
    logic [1:0]    i_Mode;
    logic [CW-1:0] i_Len;
    logic [7:0]    i_Decim;
    logic [DW-1:0] o_CMOS_Data;
    logic          o_Valid;
    logic          i_Ready;
    logic          o_Busy;
    logic          o_ADC_Done;
    logic          o_Aborted;
    logic          o_Overrun;
    logic [CW-1:0] o_Sample_Cnt;

    int            n_checks;
    int            n_fail;
    int unsigned   edge_n;
    int unsigned   seed;
    logic [DW-1:0] exp_q[$];

    pl_adc_capture #(.DATA_W(DW), .CNT_W(CW), .DEFAULT_LEN(DLEN)) dut (
        .i_CMOS_Clk   (clk),
        .i_Rst_n      (rst_n),
        .i_CMOS_Data  (i_CMOS_Data),
        .i_ADC_Work   (i_ADC_Work),
        .i_Abort      (i_Abort),
        .i_Mode       (i_Mode),
        .i_Len        (i_Len),
        .i_Decim      (i_Decim),
        .o_CMOS_Data  (o_CMOS_Data),
        .o_Valid      (o_Valid),
        .i_Ready      (i_Ready),
        .o_Busy       (o_Busy),
        .o_ADC_Done   (o_ADC_Done),
        .o_Aborted    (o_Aborted),
        .o_Overrun    (o_Overrun),
        .o_Sample_Cnt (o_Sample_Cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Bus value sampled at posedge P is bus_fn(P-1): a pseudo-random function of time.
    function automatic logic [DW-1:0] bus_fn(input int unsigned e);
        logic [31:0] t;
        t = e * 32'h9E37_79B1 + seed;
        return t[26:13];
    endfunction

    always @(posedge clk) begin
        #1;
        i_CMOS_Data = bus_fn(edge_n);
    end

    // Sample k of a run whose start request was raised when edge_n == base0.
    function automatic logic [DW-1:0] model(input logic [1:0] mode, input int k,
                                            input int unsigned base0, input int d);
        logic [31:0] kk;
        kk = 32'(k);
        case (mode)
            2'd1:    return kk[DW-1:0];
            2'd2:    return kk[0] ? 14'h1555 : 14'h2AAA;
            default: return bus_fn(base0 + 32'(k * d));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_Valid && i_Ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sample: got %0h expected none", o_CMOS_Data);
            end else begin
                check("sample", 32'(o_CMOS_Data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [CW-1:0] len,
                             input logic [7:0] decim, input int npush);
        int unsigned m;
        int n;
        int d;
        i_Mode     = mode;
        i_Len      = len;
        i_Decim    = decim;
        i_ADC_Work = 1'b1;
        m = edge_n;
        n = (len == '0) ? DLEN : int'(len);
        d = int'(decim) + 1;
        for (int k = 0; k < n && k < npush; k++) begin
            exp_q.push_back(model(mode, k, m, d));
        end
        step();
    endtask

    task automatic wait_done(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (o_ADC_Done) break;
            step();
        end
        check({name, "_done"}, 32'(o_ADC_Done), 32'd1);
    endtask

    initial begin
        int n;
        int dec;
        logic [1:0] mode;
        logic [CW-1:0] lenv;

        n_checks = 0;
        n_fail = 0;
        seed = $urandom;
        rst_n = 1'b0;
        i_ADC_Work = 1'b0;
        i_Abort = 1'b0;
        i_Mode = 2'd0;
        i_Len = '0;
        i_Decim = 8'd0;
        i_Ready = 1'b1;
        step();
        step();
        check("rst_valid", 32'(o_Valid), 0);
        check("rst_busy", 32'(o_Busy), 0);
        check("rst_done", 32'(o_ADC_Done), 0);
        check("rst_data", 32'(o_CMOS_Data), 0);
        check("rst_cnt", 32'(o_Sample_Cnt), 0);
        rst_n = 1'b1;
        step();

        // Ramp, no decimation.
        start_run(2'd1, 20'd8, 8'd0, 1000);
        i_ADC_Work = 1'b0;
        wait_done(50, "ramp8");
        check("ramp8_busy", 32'(o_Busy), 0);
        check("ramp8_cnt", 32'(o_Sample_Cnt), 8);
        check("ramp8_queue", 32'(exp_q.size()), 0);
        step();

        // Randomized runs with ignored mid-run input changes and restart attempts.
        for (int r = 0; r < 12; r++) begin
            mode = 2'($urandom_range(0, 3));
            lenv = ($urandom_range(0, 4) == 0) ? '0 : CW'($urandom_range(1, 30));
            dec  = $urandom_range(0, 3);
            n    = (lenv == '0) ? DLEN : int'(lenv);
            start_run(mode, lenv, 8'(dec), 1000);
            i_ADC_Work = 1'b0;
            i_Mode  = 2'($urandom);
            i_Len   = CW'($urandom);
            i_Decim = 8'($urandom);
            if (n * (dec + 1) > 8) begin
                step();
                i_ADC_Work = 1'b1;
                step();
                i_ADC_Work = 1'b0;
            end
            wait_done(400, "rand");
            check("rand_cnt", 32'(o_Sample_Cnt), 32'(n));
            check("rand_busy", 32'(o_Busy), 0);
            check("rand_aborted", 32'(o_Aborted), 0);
            check("rand_overrun", 32'(o_Overrun), 0);
            check("rand_queue", 32'(exp_q.size()), 0);
            step();
            step();
            check("rand_no_restart", 32'(o_Busy), 0);
        end

        // Backpressure: first two samples are overwritten.
        i_Ready = 1'b0;
        start_run(2'd1, 20'd3, 8'd0, 0);
        i_ADC_Work = 1'b0;
        exp_q.push_back(14'd2);
        step();
        step();
        step();
        check("bp_overrun", 32'(o_Overrun), 1);
        check("bp_valid", 32'(o_Valid), 1);
        check("bp_data", 32'(o_CMOS_Data), 2);
        check("bp_busy", 32'(o_Busy), 1);
        check("bp_not_done", 32'(o_ADC_Done), 0);
        i_Ready = 1'b1;
        step();
        check("bp_done", 32'(o_ADC_Done), 1);
        check("bp_valid_clr", 32'(o_Valid), 0);
        check("bp_queue", 32'(exp_q.size()), 0);
        step();

        // Abort after 10 samples with Work held high.
        start_run(2'd1, 20'd100, 8'd0, 10);
        for (int i = 0; i < 200; i++) begin
            if (o_Sample_Cnt == CW'(10)) break;
            step();
        end
        i_Abort = 1'b1;
        step();
        i_Abort = 1'b0;
        check("ab_valid", 32'(o_Valid), 0);
        check("ab_busy", 32'(o_Busy), 0);
        check("ab_done", 32'(o_ADC_Done), 1);
        check("ab_aborted", 32'(o_Aborted), 1);
        check("ab_cnt", 32'(o_Sample_Cnt), 10);
        check("ab_queue", 32'(exp_q.size()), 0);
        repeat (5) step();
        check("ab_no_restart", 32'(o_Busy), 0);
        i_ADC_Work = 1'b0;
        step();

        // A new start clears stale done/aborted.
        start_run(2'd2, 20'd5, 8'd1, 1000);
        i_ADC_Work = 1'b0;
        check("restart_done_clr", 32'(o_ADC_Done), 0);
        check("restart_ab_clr", 32'(o_Aborted), 0);
        wait_done(50, "chk");
        check("chk_queue", 32'(exp_q.size()), 0);
        step();

        // Reset in the middle of a run.
        start_run(2'd1, 20'd30, 8'd0, 1000);
        i_ADC_Work = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mrst_valid", 32'(o_Valid), 0);
        check("mrst_busy", 32'(o_Busy), 0);
        check("mrst_cnt", 32'(o_Sample_Cnt), 0);
        check("mrst_data", 32'(o_CMOS_Data), 0);
        step();
        rst_n = 1'b1;
        step();
        check("mrst_done", 32'(o_ADC_Done), 0);
        check("mrst_aborted", 32'(o_Aborted), 0);
        start_run(2'd0, 20'd6, 8'd2, 1000);
        i_ADC_Work = 1'b0;
        wait_done(60, "post_rst");
        check("post_rst_cnt", 32'(o_Sample_Cnt), 6);
        check("post_rst_queue", 32'(exp_q.size()), 0);
        step();

        // Default length and ramp wrap past 2^DATA_W.
        start_run(2'd1, '0, 8'd0, 1000);
        i_ADC_Work = 1'b0;
        wait_done(100, "deflen");
        check("deflen_cnt", 32'(o_Sample_Cnt), DLEN);
        step();
        start_run(2'd1, 20'd16390, 8'd0, 20000);
        i_ADC_Work = 1'b0;
        wait_done(17000, "wrap");
        check("wrap_cnt", 32'(o_Sample_Cnt), 16390);
        check("wrap_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
